// File: rtl/scratch_arbiter_if.sv
// One requester port of the scratchpad arbiter: request/payload in, grant and read return out.
interface scratch_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 4
);
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/scratch_arbiter.sv
// Round-robin arbiter with burst lock sharing the single-port sigmoid scratchpad between
// the network controller (A) and the readout unit (B), with a fixed-latency read-return pipe.
module scratch_arbiter #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic              i_clk,
    input  logic              i_n_rst,
    scratch_arbiter_if.slave  a_if,
    scratch_arbiter_if.slave  b_if,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    localparam int unsigned CntW = $clog2(MAX_LOCK + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_LOCK);

    typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

    state_e            r_state, w_state_d;
    logic              r_last_a, w_last_a_d;   // 1: A held the most recent grant
    logic [CntW-1:0]   r_lock_cnt, w_lock_cnt_d, w_cnt_inc;
    logic              w_gnt_a, w_gnt_b, w_arb_a, w_arb_b;
    logic [RD_LAT:0]   r_pipe_vld, r_pipe_b;
    logic [DATA_W-1:0] r_a_rdata, r_b_rdata;
    logic              w_rd_issue;

    always_comb begin
        w_arb_a      = 1'b0;
        w_arb_b      = 1'b0;
        w_state_d    = r_state;
        w_last_a_d   = r_last_a;
        w_lock_cnt_d = r_lock_cnt;
        w_cnt_inc    = (r_lock_cnt == CntMax) ? r_lock_cnt : r_lock_cnt + CntW'(1);
        case (r_state)
            StIdle: begin
                if (a_if.req && (!b_if.req || !r_last_a)) begin
                    w_arb_a = 1'b1;
                end else if (b_if.req) begin
                    w_arb_b = 1'b1;
                end
                if (w_arb_a && a_if.lock) begin
                    w_state_d    = StOwnA;
                    w_lock_cnt_d = CntW'(1);
                end else if (w_arb_b && b_if.lock) begin
                    w_state_d    = StOwnB;
                    w_lock_cnt_d = CntW'(1);
                end
            end
            StOwnA: begin
                if (r_lock_cnt == CntMax && b_if.req) begin
                    w_state_d    = StIdle;
                    w_lock_cnt_d = '0;
                    w_last_a_d   = 1'b1;
                end else begin
                    w_arb_a = a_if.req;
                    if (!a_if.lock) begin
                        w_state_d    = StIdle;
                        w_lock_cnt_d = '0;
                    end else if (a_if.req) begin
                        w_lock_cnt_d = w_cnt_inc;
                        // Hand over on the limit edge so B gets the very next cycle.
                        if (w_cnt_inc == CntMax && b_if.req) begin
                            w_state_d    = StIdle;
                            w_lock_cnt_d = '0;
                        end
                    end
                end
            end
            StOwnB: begin
                if (r_lock_cnt == CntMax && a_if.req) begin
                    w_state_d    = StIdle;
                    w_lock_cnt_d = '0;
                    w_last_a_d   = 1'b0;
                end else begin
                    w_arb_b = b_if.req;
                    if (!b_if.lock) begin
                        w_state_d    = StIdle;
                        w_lock_cnt_d = '0;
                    end else if (b_if.req) begin
                        w_lock_cnt_d = w_cnt_inc;
                        if (w_cnt_inc == CntMax && a_if.req) begin
                            w_state_d    = StIdle;
                            w_lock_cnt_d = '0;
                        end
                    end
                end
            end
            default: begin
                w_state_d    = StIdle;
                w_lock_cnt_d = '0;
            end
        endcase
        if (w_arb_a) w_last_a_d = 1'b1;
        if (w_arb_b) w_last_a_d = 1'b0;
    end

    // Grants are suppressed while reset is held so the macro never sees a stray write.
    assign w_gnt_a = w_arb_a & i_n_rst;
    assign w_gnt_b = w_arb_b & i_n_rst;
    assign a_if.gnt = w_gnt_a;
    assign b_if.gnt = w_gnt_b;

    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_gnt_a) begin
            o_mem_we    = a_if.we;
            o_mem_addr  = a_if.addr;
            o_mem_wdata = a_if.wdata;
        end else if (w_gnt_b) begin
            o_mem_we    = b_if.we;
            o_mem_addr  = b_if.addr;
            o_mem_wdata = b_if.wdata;
        end
    end

    assign w_rd_issue = (w_gnt_a & ~a_if.we) | (w_gnt_b & ~b_if.we);

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_state    <= StIdle;
            r_last_a   <= 1'b0;
            r_lock_cnt <= '0;
            r_pipe_vld <= '0;
            r_pipe_b   <= '0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            r_state    <= w_state_d;
            r_last_a   <= w_last_a_d;
            r_lock_cnt <= w_lock_cnt_d;
            r_pipe_vld <= {r_pipe_vld[RD_LAT-1:0], w_rd_issue};
            r_pipe_b   <= {r_pipe_b[RD_LAT-1:0], w_gnt_b};
            if (r_pipe_vld[RD_LAT-1] && !r_pipe_b[RD_LAT-1]) r_a_rdata <= i_mem_rdata;
            if (r_pipe_vld[RD_LAT-1] &&  r_pipe_b[RD_LAT-1]) r_b_rdata <= i_mem_rdata;
        end
    end

    assign a_if.rvalid = r_pipe_vld[RD_LAT] & ~r_pipe_b[RD_LAT];
    assign b_if.rvalid = r_pipe_vld[RD_LAT] &  r_pipe_b[RD_LAT];
    assign a_if.rdata  = r_a_rdata;
    assign b_if.rdata  = r_b_rdata;
endmodule

// File: tb/tb_scratch_arbiter.sv
// Bench for scratch_arbiter: scratchpad model plus a read-return scoreboard per port.
module tb_scratch_arbiter;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    scratch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a_if ();
    scratch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_if ();

    scratch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_LOCK(4)) u_dut (
        .i_clk       (clk),
        .i_n_rst     (n_rst),
        .a_if        (a_if),
        .b_if        (b_if),
        .o_mem_addr  (mem_addr),
        .o_mem_we    (mem_we),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return DATA_W'(i * 3);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scratchpad model with RD_LAT=1 synchronous read.
    logic [DATA_W-1:0] mem [32];
    bit mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    logic [DATA_W-1:0] ref_mem [32];
    bit ref_init = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!ref_init) begin
            for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
            ref_init = 1'b1;
        end
        if (!n_rst) begin
            qa.delete();
            qb.delete();
        end else begin
            check_eq("one_gnt", 32'(a_if.gnt & b_if.gnt), 0);
            if (a_if.gnt) begin
                if (a_if.we) ref_mem[a_if.addr] = a_if.wdata;
                else qa.push_back('{data: ref_mem[a_if.addr], due: cyc + RD_LAT + 1});
            end
            if (b_if.gnt) begin
                if (b_if.we) ref_mem[b_if.addr] = b_if.wdata;
                else qb.push_back('{data: ref_mem[b_if.addr], due: cyc + RD_LAT + 1});
            end
            if (a_if.rvalid) begin
                if (qa.size() == 0) begin
                    check_eq("a_rvalid_spurious", 1, 0);
                end else begin
                    e = qa.pop_front();
                    check_eq("a_rdata", a_if.rdata, e.data);
                    check_eq("a_rlat", cyc, e.due);
                end
            end
            if (b_if.rvalid) begin
                if (qb.size() == 0) begin
                    check_eq("b_rvalid_spurious", 1, 0);
                end else begin
                    e = qb.pop_front();
                    check_eq("b_rdata", b_if.rdata, e.data);
                    check_eq("b_rlat", cyc, e.due);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.lock = 1'b0; a_if.addr = '0; a_if.wdata = '0;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.lock = 1'b0; b_if.addr = '0; b_if.wdata = '0;
    endtask

    task automatic pulse_reset();
        next_cycle();
        n_rst = 1'b0;
        next_cycle();
        n_rst = 1'b1;
    endtask

    initial begin
        idle_inputs();
        // Reset held with toggling inputs.
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            a_if.req = 1'($urandom); a_if.we = 1'($urandom); a_if.lock = 1'($urandom);
            a_if.addr = 5'($urandom); a_if.wdata = 4'($urandom);
            b_if.req = 1'($urandom); b_if.we = 1'($urandom); b_if.lock = 1'($urandom);
            b_if.addr = 5'($urandom); b_if.wdata = 4'($urandom);
            @(negedge clk);
            check_eq("rst_a_rvalid", a_if.rvalid, 0);
            check_eq("rst_b_rvalid", b_if.rvalid, 0);
            check_eq("rst_a_rdata", a_if.rdata, 0);
            check_eq("rst_b_rdata", b_if.rdata, 0);
            check_eq("rst_mem_we", mem_we, 0);
        end
        next_cycle();
        idle_inputs();
        n_rst = 1'b1;
        next_cycle();

        // Single A read of address 3.
        a_if.req = 1'b1; a_if.addr = 5'd3;
        @(negedge clk);
        check_eq("rd_a_gnt", a_if.gnt, 1);
        check_eq("rd_b_gnt", b_if.gnt, 0);
        check_eq("rd_mem_addr", mem_addr, 3);
        check_eq("rd_mem_we", mem_we, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check_eq("rd_rvalid_c1", a_if.rvalid, 0);
        next_cycle();
        @(negedge clk);
        check_eq("rd_rvalid_c2", a_if.rvalid, 1);
        check_eq("rd_rdata_c2", a_if.rdata, 4'h9);
        repeat (3) @(negedge clk);
        check_eq("rd_rvalid_after", a_if.rvalid, 0);
        check_eq("rd_rdata_held", a_if.rdata, 4'h9);

        // Both requesting continuously: strict alternation starting with A.
        pulse_reset();
        a_if.req = 1'b1; a_if.addr = 5'd4;
        b_if.req = 1'b1; b_if.addr = 5'd10;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("rr_a_gnt", a_if.gnt, 32'(i % 2 == 0));
            check_eq("rr_b_gnt", b_if.gnt, 32'(i % 2 == 1));
            next_cycle();
            a_if.addr = 5'(4 + i);
            b_if.addr = 5'(10 + i);
        end
        idle_inputs();
        repeat (4) next_cycle();

        // Write then read-back of address 8.
        a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 5'd8; a_if.wdata = 4'h5;
        @(negedge clk);
        check_eq("wr_mem_we", mem_we, 1);
        check_eq("wr_mem_addr", mem_addr, 8);
        check_eq("wr_mem_wdata", mem_wdata, 4'h5);
        next_cycle();
        a_if.we = 1'b0;
        @(negedge clk);
        check_eq("wr_rd_gnt", a_if.gnt, 1);
        check_eq("wr_rd_mem_we", mem_we, 0);
        next_cycle();
        idle_inputs();
        repeat (3) @(negedge clk);
        check_eq("wr_readback", a_if.rdata, 4'h5);
        next_cycle();

        // Burst lock: 4 A grants, then B once, then A again.
        pulse_reset();
        a_if.req = 1'b1; a_if.lock = 1'b1; a_if.we = 1'b1; a_if.addr = 5'd20; a_if.wdata = 4'h0;
        b_if.req = 1'b1; b_if.addr = 5'd8;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("lock_a_gnt", a_if.gnt, 32'(i != 4));
            check_eq("lock_b_gnt", b_if.gnt, 32'(i == 4));
            next_cycle();
            a_if.wdata = 4'(i + 1);
        end
        idle_inputs();
        repeat (4) next_cycle();

        // Reset right after a B read grant flushes the return.
        b_if.req = 1'b1; b_if.addr = 5'd3;
        @(negedge clk);
        check_eq("flush_b_gnt", b_if.gnt, 1);
        next_cycle();
        idle_inputs();
        n_rst = 1'b0;
        @(negedge clk);
        check_eq("flush_rvalid_rst", b_if.rvalid, 0);
        next_cycle();
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("flush_rvalid_post", b_if.rvalid, 0);
            next_cycle();
        end
        a_if.req = 1'b1; a_if.addr = 5'd1;
        b_if.req = 1'b1; b_if.addr = 5'd2;
        @(negedge clk);
        check_eq("flush_tie_a", a_if.gnt, 1);
        check_eq("flush_tie_b", b_if.gnt, 0);
        next_cycle();
        idle_inputs();
        repeat (5) next_cycle();

        check_eq("a_pending", qa.size(), 0);
        check_eq("b_pending", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
